// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scan/debounce front end.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] COL_IDLE = 4'hf;

    // Entry k holds the ASCII for key code k = {row_idx, col_idx}; entry 0 sits in the LSBs.
    localparam logic [16*8-1:0] KEY_ASCII_LUT = {
        8'h44, 8'h23, 8'h30, 8'h2a,
        8'h43, 8'h39, 8'h38, 8'h37,
        8'h42, 8'h36, 8'h35, 8'h34,
        8'h41, 8'h33, 8'h32, 8'h31
    };

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] key_to_ascii(input logic [3:0] code);
        return KEY_ASCII_LUT[{code, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the clk domain.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with row synchronization, press/release debounce and
// a single registered key event per press.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] key_ascii,
    output logic       key_held,
    output logic       multi_err
);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Rows lag the column drive by the two synchronizer flops.
    localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(2);

    logic [3:0]       row_s;
    state_t           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       row_lat_q, row_lat_d;
    logic             key_valid_d, key_held_d, multi_err_d;
    logic [3:0]       key_code_d, new_code;
    logic [7:0]       key_ascii_d;
    logic [3:0]       col_out_d;
    logic             row_single, row_multi, settled;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (row_in),
        .q    (row_s)
    );

    assign row_single = ($countones(row_s) == 1);
    assign row_multi  = ($countones(row_s) > 1);
    assign settled    = (cnt_q >= SETTLE);
    assign new_code   = {onehot_to_idx(row_lat_q), col_idx_q};

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        row_lat_d   = row_lat_q;
        key_valid_d = 1'b0;
        multi_err_d = 1'b0;
        key_code_d  = key_code;
        key_ascii_d = key_ascii;
        key_held_d  = key_held;

        if (!en) begin
            state_d    = IDLE;
            key_held_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SCAN;
                    col_idx_d = 2'd0;
                    cnt_d     = '0;
                end
                SCAN: begin
                    // Stale rows from the previous column are ignored until settled.
                    if (row_single && settled) begin
                        row_lat_d = row_s;
                        state_d   = DEBOUNCE;
                        cnt_d     = '0;
                    end else if (row_multi && settled) begin
                        multi_err_d = 1'b1;
                        col_idx_d   = col_idx_q + 2'd1;
                        cnt_d       = '0;
                    end else if (cnt_q == SCAN_LAST) begin
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_s != row_lat_q) begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        // Event outputs register on entry so they are visible during PRESSED.
                        state_d     = PRESSED;
                        cnt_d       = '0;
                        key_valid_d = 1'b1;
                        key_code_d  = new_code;
                        key_ascii_d = key_to_ascii(new_code);
                        key_held_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
                RELEASE: begin
                    if (row_s != 4'h0) begin
                        cnt_d = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        key_held_d = 1'b0;
                        col_idx_d  = col_idx_q + 2'd1;
                        cnt_d      = '0;
                        state_d    = SCAN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        col_out_d = (state_d == IDLE) ? COL_IDLE : ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            col_idx_q <= 2'd0;
            cnt_q     <= '0;
            row_lat_q <= 4'h0;
            col_out   <= COL_IDLE;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_ascii <= 8'h00;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            row_lat_q <= row_lat_d;
            col_out   <= col_out_d;
            key_valid <= key_valid_d;
            key_code  <= key_code_d;
            key_ascii <= key_ascii_d;
            key_held  <= key_held_d;
            multi_err <= multi_err_d;
        end
    end

endmodule
